fetch_pc_stage: RTL and testbench

//  Owns the architectural PC and the IF/ID pipeline register. It drives the instruction-memory

---
 rtl/fetch_pc_stage_pkg.sv | 51 +++++
 rtl/fetch_pc_stage_if.sv | 31 +++
 rtl/fetch_pc_stage_pc_reg.sv | 24 ++
 rtl/fetch_pc_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_pc_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_stage_pkg.sv
// Shared definitions for the fetch/PC stage: state encoding, reset/NOP constants, IF/ID record, PC adder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package fetch_pc_stage_pkg;

    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

    typedef enum logic [1:0] {
        S_FETCH    = 2'b00,
        S_WAIT_MEM = 2'b01,
        S_HALTED   = 2'b10
    } fetch_state_t;

    // IF/ID pipeline record handed to decode.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
        logic        valid;
    } ifid_t;

    // 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
    // feeding a second-level lookahead for the group carries. Returns {cout, sum}.
    function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = cin;
        for (int k = 0; k < 4; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 0) c[i] = gc[i/4];
            else              c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        return {gc[4], p ^ c};
    endfunction

endpackage

// File: rtl/fetch_pc_stage_if.sv
// Fetch-stage bundle: redirect/stall/halt controls, instruction-memory port, next-PC and IF/ID outputs.
// Latency: n/a (wiring only).
// Backpressure: stall_id holds IF/ID; imem_stall/imem_done pace the memory request.
interface fetch_pc_stage_if;
    logic [15:0] nextpc;
    logic        redirect;
    logic        stall_id;
    logic        halt;
    logic [15:0] imem_instr;
    logic        imem_done;
    logic        imem_stall;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] pc_plus2;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        fetch_busy;

    // master: the fetch stage itself.
    modport master (
        input  nextpc, redirect, stall_id, halt, imem_instr, imem_done, imem_stall,
        output imem_addr, imem_rd, pc_plus2, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_busy
    );

    // slave: the surrounding pipeline/memory.
    modport slave (
        output nextpc, redirect, stall_id, halt, imem_instr, imem_done, imem_stall,
        input  imem_addr, imem_rd, pc_plus2, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_busy
    );
endinterface

// File: rtl/fetch_pc_stage_pc_reg.sv
// 16-bit load-enabled register, async active-low reset to RESET_VAL; holds PC and the pending redirect target.
// Latency: 1 cycle from i_d/i_en to o_q.
// Backpressure: none; i_en=0 holds the value.
// Ports: clk, rst (active-low async), i_en, i_d[15:0], o_q[15:0].
module fetch_pc_stage_pc_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_q <= RESET_VAL;
        else if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_pc_stage.sv
// Architectural PC + IF/ID register: drives imem address, feeds PC+2 to next-PC adder, loads redirect targets.
// Latency: fetched word reaches IF/ID one edge after imem_done; redirect shows on imem_addr the next cycle.
// Backpressure: stall_id holds PC and IF/ID (word is refetched); imem_stall parks in WAIT_MEM with address held.
// Ports: clk, rst (active-low async), io_fetch (fetch_pc_stage_if.master: controls, imem port, IF/ID outputs).
module fetch_pc_stage
    import fetch_pc_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    fetch_pc_stage_if.master io_fetch
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [15:0] w_pc;
    logic [15:0] w_pc_nxt;
    logic        w_pc_en;
    logic [15:0] w_pc_plus2;
    logic        w_unused_cout;

    logic [15:0] w_pend_pc;
    logic        w_pend_en;
    logic        r_pend_valid;
    logic        w_pend_valid_nxt;
    logic        r_halt_pend;
    logic        w_halt_pend_nxt;

    ifid_t       r_ifid;
    ifid_t       w_ifid_nxt;
    logic        w_ifid_en;
    ifid_t       w_bubble;
    ifid_t       w_fetched;
    logic        w_accept;

    assign {w_unused_cout, w_pc_plus2} = cla16(w_pc, 16'd2, 1'b0);

    assign w_bubble  = '{instr: NOP_INSTR, pc_plus2: 16'h0000, valid: 1'b0};
    assign w_fetched = '{instr: io_fetch.imem_instr, pc_plus2: w_pc_plus2, valid: 1'b1};

    // A word is only taken in FETCH when memory both returns it and is not busy.
    assign w_accept = io_fetch.imem_done & ~io_fetch.imem_stall;

    fetch_pc_stage_pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pc_en),
        .i_d  (w_pc_nxt),
        .o_q  (w_pc)
    );

    // Redirect seen while a fetch is outstanding; the latest one wins.
    fetch_pc_stage_pc_reg #(.RESET_VAL(RESET_PC)) u_pend_pc (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pend_en),
        .i_d  (io_fetch.nextpc),
        .o_q  (w_pend_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_FETCH;
            r_pend_valid <= 1'b0;
            r_halt_pend  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_halt_pend  <= w_halt_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_ifid <= '{instr: NOP_INSTR, pc_plus2: 16'h0000, valid: 1'b0};
        else if (w_ifid_en) r_ifid <= w_ifid_nxt;
    end

    // Any cycle that delivers no instruction injects a bubble unless decode is
    // stalled, in which case IF/ID keeps what decode has not yet consumed.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_en          = 1'b0;
        w_pc_nxt         = w_pc_plus2;
        w_pend_en        = 1'b0;
        w_pend_valid_nxt = r_pend_valid;
        w_halt_pend_nxt  = r_halt_pend;
        w_ifid_en        = 1'b0;
        w_ifid_nxt       = w_bubble;

        case (r_state)
            S_FETCH: begin
                if (io_fetch.halt) begin
                    w_state_nxt = S_HALTED;
                    w_ifid_en   = 1'b1;
                end else if (io_fetch.redirect) begin
                    w_pc_en   = 1'b1;
                    w_pc_nxt  = io_fetch.nextpc;
                    w_ifid_en = 1'b1;
                end else if (w_accept) begin
                    if (!io_fetch.stall_id) begin
                        w_pc_en    = 1'b1;
                        w_ifid_en  = 1'b1;
                        w_ifid_nxt = w_fetched;
                    end
                end else begin
                    w_state_nxt = S_WAIT_MEM;
                    w_ifid_en   = ~io_fetch.stall_id;
                end
            end

            S_WAIT_MEM: begin
                // Halt cannot abandon a request the memory has already taken:
                // remember it, let the access finish, then drop the word.
                if (io_fetch.halt || r_halt_pend) begin
                    if (io_fetch.imem_done) begin
                        w_state_nxt      = S_HALTED;
                        w_halt_pend_nxt  = 1'b0;
                        w_pend_valid_nxt = 1'b0;
                        w_ifid_en        = 1'b1;
                    end else begin
                        w_halt_pend_nxt = 1'b1;
                        w_ifid_en       = ~io_fetch.stall_id;
                    end
                end else if (io_fetch.imem_done) begin
                    w_state_nxt = S_FETCH;
                    if (io_fetch.redirect || r_pend_valid) begin
                        w_pc_en          = 1'b1;
                        w_pc_nxt         = io_fetch.redirect ? io_fetch.nextpc : w_pend_pc;
                        w_pend_valid_nxt = 1'b0;
                        w_ifid_en        = 1'b1;
                    end else if (!io_fetch.stall_id) begin
                        w_pc_en    = 1'b1;
                        w_ifid_en  = 1'b1;
                        w_ifid_nxt = w_fetched;
                    end
                end else begin
                    if (io_fetch.redirect) begin
                        w_pend_en        = 1'b1;
                        w_pend_valid_nxt = 1'b1;
                    end
                    w_ifid_en = ~io_fetch.stall_id;
                end
            end

            S_HALTED: begin
                w_ifid_en = 1'b1;
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign io_fetch.imem_addr     = w_pc;
    // Gated by rst so no request escapes while reset is held.
    assign io_fetch.imem_rd       = rst & (r_state != S_HALTED);
    assign io_fetch.pc_plus2      = w_pc_plus2;
    assign io_fetch.ifid_instr    = r_ifid.instr;
    assign io_fetch.ifid_pc_plus2 = r_ifid.pc_plus2;
    assign io_fetch.ifid_valid    = r_ifid.valid;
    assign io_fetch.fetch_busy    = (r_state == S_WAIT_MEM);

endmodule

// File: tb/tb_fetch_pc_stage.sv
module tb_fetch_pc_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_pc_stage_if bus();

    fetch_pc_stage dut (
        .clk      (clk),
        .rst      (rst),
        .io_fetch (bus)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        bus.nextpc     = 16'h0000;
        bus.redirect   = 1'b0;
        bus.stall_id   = 1'b0;
        bus.halt       = 1'b0;
        bus.imem_instr = 16'h0000;
        bus.imem_done  = 1'b0;
        bus.imem_stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (bus.imem_rd !== 1'b0) $display("FAIL rst_rd: got %b want 0", bus.imem_rd); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0000) $display("FAIL rst_addr: got %h want 0000", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.ifid_instr !== 16'h0800) $display("FAIL rst_instr: got %h want 0800", bus.ifid_instr); else n_pass++;
        n_checks++; if (bus.ifid_pc_plus2 !== 16'h0000) $display("FAIL rst_pp2: got %h want 0000", bus.ifid_pc_plus2); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.ifid_valid); else n_pass++;
        n_checks++; if (bus.fetch_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.fetch_busy); else n_pass++;
        n_checks++; if (bus.pc_plus2 !== 16'h0002) $display("FAIL rst_pcp2: got %h want 0002", bus.pc_plus2); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.imem_rd !== 1'b1) $display("FAIL rel_rd: got %b want 1", bus.imem_rd); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [15:0] exp_addr;
        logic [15:0] exp_instr;
        bus.imem_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_addr       = 16'(2 * i);
            exp_instr      = 16'h1000 + 16'(i);
            bus.imem_instr = exp_instr;
            n_checks++; if (bus.imem_addr !== exp_addr) $display("FAIL seq_addr[%0d]: got %h want %h", i, bus.imem_addr, exp_addr); else n_pass++;
            cycle();
            n_checks++; if (bus.ifid_pc_plus2 !== exp_addr + 16'd2) $display("FAIL seq_pp2[%0d]: got %h want %h", i, bus.ifid_pc_plus2, exp_addr + 16'd2); else n_pass++;
            n_checks++; if (bus.ifid_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b want 1", i, bus.ifid_valid); else n_pass++;
            n_checks++; if (bus.ifid_instr !== exp_instr) $display("FAIL seq_instr[%0d]: got %h want %h", i, bus.ifid_instr, exp_instr); else n_pass++;
        end
    endtask

    task automatic test_redirect();
        bus.imem_instr = 16'h2000;
        repeat (4) cycle();
        n_checks++; if (bus.imem_addr !== 16'h0010) $display("FAIL redir_pre_addr: got %h want 0010", bus.imem_addr); else n_pass++;
        bus.redirect = 1'b1;
        bus.nextpc   = 16'h0040;
        cycle();
        bus.redirect = 1'b0;
        n_checks++; if (bus.imem_addr !== 16'h0040) $display("FAIL redir_addr: got %h want 0040", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.ifid_instr !== 16'h0800) $display("FAIL redir_instr: got %h want 0800", bus.ifid_instr); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL redir_valid: got %b want 0", bus.ifid_valid); else n_pass++;
        n_checks++; if (bus.ifid_pc_plus2 !== 16'h0000) $display("FAIL redir_pp2: got %h want 0000", bus.ifid_pc_plus2); else n_pass++;
    endtask

    task automatic test_wait_redirect();
        bus.redirect = 1'b1;
        bus.nextpc   = 16'h0008;
        cycle();
        bus.redirect   = 1'b0;
        bus.imem_done  = 1'b0;
        bus.imem_stall = 1'b1;
        n_checks++; if (bus.imem_addr !== 16'h0008) $display("FAIL wait_c1_addr: got %h want 0008", bus.imem_addr); else n_pass++;
        cycle();
        n_checks++; if (bus.fetch_busy !== 1'b1) $display("FAIL wait_c2_busy: got %b want 1", bus.fetch_busy); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0008) $display("FAIL wait_c2_addr: got %h want 0008", bus.imem_addr); else n_pass++;
        bus.redirect = 1'b1;
        bus.nextpc   = 16'h0100;
        cycle();
        bus.redirect = 1'b0;
        bus.nextpc   = 16'h0000;
        n_checks++; if (bus.imem_addr !== 16'h0008) $display("FAIL wait_c3_addr: got %h want 0008", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.fetch_busy !== 1'b1) $display("FAIL wait_c3_busy: got %b want 1", bus.fetch_busy); else n_pass++;
        n_checks++; if (bus.imem_rd !== 1'b1) $display("FAIL wait_c3_rd: got %b want 1", bus.imem_rd); else n_pass++;
        cycle();
        n_checks++; if (bus.imem_addr !== 16'h0008) $display("FAIL wait_c4_addr: got %h want 0008", bus.imem_addr); else n_pass++;
        bus.imem_stall = 1'b0;
        bus.imem_done  = 1'b1;
        bus.imem_instr = 16'hBEEF;
        cycle();
        n_checks++; if (bus.imem_addr !== 16'h0100) $display("FAIL wait_done_addr: got %h want 0100", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.fetch_busy !== 1'b0) $display("FAIL wait_done_busy: got %b want 0", bus.fetch_busy); else n_pass++;
        n_checks++; if (bus.ifid_instr !== 16'h0800) $display("FAIL wait_done_instr: got %h want 0800", bus.ifid_instr); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL wait_done_valid: got %b want 0", bus.ifid_valid); else n_pass++;
    endtask

    task automatic test_stall_id();
        bus.imem_instr = 16'h1234;
        cycle();
        n_checks++; if (bus.ifid_instr !== 16'h1234) $display("FAIL sid_load_instr: got %h want 1234", bus.ifid_instr); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0102) $display("FAIL sid_load_addr: got %h want 0102", bus.imem_addr); else n_pass++;
        bus.stall_id   = 1'b1;
        bus.imem_instr = 16'h5678;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++; if (bus.ifid_instr !== 16'h1234) $display("FAIL sid_hold_instr[%0d]: got %h want 1234", i, bus.ifid_instr); else n_pass++;
            n_checks++; if (bus.ifid_pc_plus2 !== 16'h0102) $display("FAIL sid_hold_pp2[%0d]: got %h want 0102", i, bus.ifid_pc_plus2); else n_pass++;
            n_checks++; if (bus.imem_addr !== 16'h0102) $display("FAIL sid_hold_addr[%0d]: got %h want 0102", i, bus.imem_addr); else n_pass++;
            n_checks++; if (bus.ifid_valid !== 1'b1) $display("FAIL sid_hold_valid[%0d]: got %b want 1", i, bus.ifid_valid); else n_pass++;
        end
        bus.stall_id = 1'b0;
        cycle();
        n_checks++; if (bus.ifid_instr !== 16'h5678) $display("FAIL sid_rel_instr: got %h want 5678", bus.ifid_instr); else n_pass++;
        n_checks++; if (bus.ifid_pc_plus2 !== 16'h0104) $display("FAIL sid_rel_pp2: got %h want 0104", bus.ifid_pc_plus2); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0104) $display("FAIL sid_rel_addr: got %h want 0104", bus.imem_addr); else n_pass++;
        bus.imem_instr = 16'h9ABC;
        cycle();
        n_checks++; if (bus.ifid_instr !== 16'h9ABC) $display("FAIL sid_next_instr: got %h want 9abc", bus.ifid_instr); else n_pass++;
        n_checks++; if (bus.ifid_pc_plus2 !== 16'h0106) $display("FAIL sid_next_pp2: got %h want 0106", bus.ifid_pc_plus2); else n_pass++;
    endtask

    task automatic test_wrap();
        bus.redirect = 1'b1;
        bus.nextpc   = 16'hFFFE;
        cycle();
        bus.redirect = 1'b0;
        n_checks++; if (bus.imem_addr !== 16'hFFFE) $display("FAIL wrap_addr: got %h want fffe", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.pc_plus2 !== 16'h0000) $display("FAIL wrap_pcp2: got %h want 0000", bus.pc_plus2); else n_pass++;
        bus.imem_instr = 16'h4321;
        cycle();
        n_checks++; if (bus.imem_addr !== 16'h0000) $display("FAIL wrap_next_addr: got %h want 0000", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.ifid_pc_plus2 !== 16'h0000) $display("FAIL wrap_pp2: got %h want 0000", bus.ifid_pc_plus2); else n_pass++;
        n_checks++; if (bus.ifid_instr !== 16'h4321) $display("FAIL wrap_instr: got %h want 4321", bus.ifid_instr); else n_pass++;
    endtask

    task automatic test_halt_reset();
        cycle();
        n_checks++; if (bus.imem_addr !== 16'h0002) $display("FAIL halt_pre_addr: got %h want 0002", bus.imem_addr); else n_pass++;
        bus.halt = 1'b1;
        cycle();
        bus.halt = 1'b0;
        n_checks++; if (bus.imem_rd !== 1'b0) $display("FAIL halt_rd: got %b want 0", bus.imem_rd); else n_pass++;
        n_checks++; if (bus.ifid_valid !== 1'b0) $display("FAIL halt_valid: got %b want 0", bus.ifid_valid); else n_pass++;
        bus.redirect = 1'b1;
        bus.nextpc   = 16'h2000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (bus.imem_rd !== 1'b0) $display("FAIL halted_rd[%0d]: got %b want 0", i, bus.imem_rd); else n_pass++;
            n_checks++; if (bus.imem_addr !== 16'h0002) $display("FAIL halted_addr[%0d]: got %h want 0002", i, bus.imem_addr); else n_pass++;
        end
        bus.redirect  = 1'b0;
        bus.imem_done = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.imem_addr !== 16'h0000) $display("FAIL halt_rst_addr: got %h want 0000", bus.imem_addr); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.imem_rd !== 1'b1) $display("FAIL halt_rel_rd: got %b want 1", bus.imem_rd); else n_pass++;
        bus.imem_done = 1'b1;
        bus.redirect  = 1'b1;
        bus.nextpc    = 16'h0300;
        cycle();
        bus.redirect   = 1'b0;
        bus.imem_done  = 1'b0;
        bus.imem_stall = 1'b1;
        cycle();
        n_checks++; if (bus.fetch_busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", bus.fetch_busy); else n_pass++;
        n_checks++; if (bus.imem_addr !== 16'h0300) $display("FAIL mid_addr: got %h want 0300", bus.imem_addr); else n_pass++;
        #3;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.imem_addr !== 16'h0000) $display("FAIL mid_rst_addr: got %h want 0000", bus.imem_addr); else n_pass++;
        n_checks++; if (bus.fetch_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", bus.fetch_busy); else n_pass++;
        n_checks++; if (bus.imem_rd !== 1'b0) $display("FAIL mid_rst_rd: got %b want 0", bus.imem_rd); else n_pass++;
        #1;
        bus.imem_stall = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.imem_rd !== 1'b1) $display("FAIL mid_rel_rd: got %b want 1", bus.imem_rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_wait_redirect();
        test_stall_id();
        test_wrap();
        test_halt_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
